// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pkg
// Purpose  : Shared FSM state type and width helper for the systolic multiplier
// Revision : 1.0
// ============================================================================
package systolic_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    // Address width for the larger of two depths; never narrower than one bit.
    function automatic int clog2_max(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_pe.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pe
// Purpose  : One processing element: forwards a right / b down, MACs when valid
// Revision : 1.0
// ============================================================================
module systolic_pe #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 18
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_clear,
    input  logic                         i_valid,
    input  logic signed [DATA_WIDTH-1:0] i_a,
    input  logic signed [DATA_WIDTH-1:0] i_b,
    output logic                         o_valid,
    output logic signed [DATA_WIDTH-1:0] o_a,
    output logic signed [DATA_WIDTH-1:0] o_b,
    output logic signed [ACC_WIDTH-1:0]  o_acc
);

    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]    w_prod_ext;
    logic                           r_valid;
    logic signed [DATA_WIDTH-1:0]   r_a;
    logic signed [DATA_WIDTH-1:0]   r_b;
    logic signed [ACC_WIDTH-1:0]    r_acc;

    assign w_prod     = (2*DATA_WIDTH)'(i_a) * (2*DATA_WIDTH)'(i_b);
    assign w_prod_ext = ACC_WIDTH'(w_prod);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
        end else begin
            r_valid <= i_valid;
            r_a     <= i_a;
            r_b     <= i_b;
            if (i_valid) begin
                r_acc <= r_acc + w_prod_ext;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_a     = r_a;
    assign o_b     = r_b;
    assign o_acc   = r_acc;

endmodule
`default_nettype wire

// File: rtl/systolic_matmul.sv
`default_nettype none
// ============================================================================
// Module   : systolic_matmul
// Purpose  : C = A x B on an M x N output-stationary systolic grid
// Revision : 1.0
// ============================================================================
module systolic_matmul
    import systolic_pkg::*;
#(
    parameter int M          = 3,
    parameter int KD         = 3,
    parameter int N          = 3,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(KD)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   wr_en,
    input  logic                                   wr_sel,
    input  logic [clog2_max(M*KD, KD*N)-1:0]       wr_addr,
    input  logic signed [DATA_WIDTH-1:0]           wr_data,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   done,
    input  logic [clog2_max(M*N, 1)-1:0]           rd_addr,
    output logic signed [ACC_WIDTH-1:0]            rd_data
);

    localparam int C_T      = KD + M + N - 2;
    localparam int C_CW     = clog2_max(C_T, 2);
    localparam int C_A_SIZE = M * KD;
    localparam int C_B_SIZE = KD * N;
    localparam int C_C_SIZE = M * N;

    state_t                       r_state;
    state_t                       w_next;
    logic [C_CW-1:0]              r_cnt;
    logic                         w_clear;
    logic                         w_compute;
    logic signed [DATA_WIDTH-1:0] r_abuf [C_A_SIZE];
    logic signed [DATA_WIDTH-1:0] r_bbuf [C_B_SIZE];
    logic signed [ACC_WIDTH-1:0]  r_rd_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_clear) begin
                r_cnt <= '0;
            end else if (w_compute) begin
                r_cnt <= r_cnt + C_CW'(1);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_COMPUTE;
            S_COMPUTE: if (r_cnt == C_CW'(C_T - 1)) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        w_clear   = 1'b0;
        w_compute = 1'b0;
        case (r_state)
            S_IDLE:    w_clear = start;
            S_COMPUTE: begin busy = 1'b1; w_compute = 1'b1; end
            S_DONE:    begin busy = 1'b1; done = 1'b1; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int x = 0; x < C_A_SIZE; x++) r_abuf[x] <= '0;
            for (int x = 0; x < C_B_SIZE; x++) r_bbuf[x] <= '0;
        end else if (wr_en && r_state == S_IDLE) begin
            if (!wr_sel && int'(wr_addr) < C_A_SIZE) r_abuf[int'(wr_addr)] <= wr_data;
            if (wr_sel && int'(wr_addr) < C_B_SIZE)  r_bbuf[int'(wr_addr)] <= wr_data;
        end
    end

    // Skewed edge feed: row i / column j sees element k = cnt - i (or cnt - j).
    logic signed [DATA_WIDTH-1:0] w_a_edge [M];
    logic                         w_v_edge [M];
    logic signed [DATA_WIDTH-1:0] w_b_edge [N];

    always_comb begin
        for (int i = 0; i < M; i++) begin
            w_a_edge[i] = '0;
            w_v_edge[i] = 1'b0;
            if (w_compute && int'(r_cnt) >= i && int'(r_cnt) - i < KD) begin
                w_a_edge[i] = r_abuf[i*KD + int'(r_cnt) - i];
                w_v_edge[i] = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            w_b_edge[j] = '0;
            if (w_compute && int'(r_cnt) >= j && int'(r_cnt) - j < KD) begin
                w_b_edge[j] = r_bbuf[(int'(r_cnt) - j)*N + j];
            end
        end
    end

    logic signed [DATA_WIDTH-1:0] w_a_out [M][N];
    logic signed [DATA_WIDTH-1:0] w_b_out [M][N];
    logic                         w_v_out [M][N];
    logic signed [ACC_WIDTH-1:0]  w_acc   [C_C_SIZE];
    logic [M-1:0]                 w_unused_east;
    logic [N-1:0]                 w_unused_south;

    genvar gi, gj;
    generate
        for (gi = 0; gi < M; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_col
                logic signed [DATA_WIDTH-1:0] w_a_in;
                logic signed [DATA_WIDTH-1:0] w_b_in;
                logic                         w_v_in;

                if (gj == 0) begin : g_left
                    assign w_a_in = w_a_edge[gi];
                    assign w_v_in = w_v_edge[gi];
                end else begin : g_from_left
                    assign w_a_in = w_a_out[gi][gj-1];
                    assign w_v_in = w_v_out[gi][gj-1];
                end

                if (gi == 0) begin : g_top
                    assign w_b_in = w_b_edge[gj];
                end else begin : g_from_above
                    assign w_b_in = w_b_out[gi-1][gj];
                end

                systolic_pe #(
                    .DATA_WIDTH (DATA_WIDTH),
                    .ACC_WIDTH  (ACC_WIDTH)
                ) u_pe (
                    .clk     (clk),
                    .reset   (reset),
                    .i_clear (w_clear),
                    .i_valid (w_v_in),
                    .i_a     (w_a_in),
                    .i_b     (w_b_in),
                    .o_valid (w_v_out[gi][gj]),
                    .o_a     (w_a_out[gi][gj]),
                    .o_b     (w_b_out[gi][gj]),
                    .o_acc   (w_acc[gi*N + gj])
                );
            end
            assign w_unused_east[gi] = ^{w_a_out[gi][N-1], w_v_out[gi][N-1]};
        end
        for (gj = 0; gj < N; gj++) begin : g_south
            assign w_unused_south[gj] = ^w_b_out[M-1][gj];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else if (int'(rd_addr) < C_C_SIZE) begin
            r_rd_data <= w_acc[int'(rd_addr)];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_systolic_matmul.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_matmul
// Purpose  : Directed self-checking bench for systolic_matmul (3x3 and 2x4x3)
// Revision : 1.0
// ============================================================================
module tb_systolic_matmul;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic               wr_sel;
    logic [3:0]         wr_addr;
    logic signed [7:0]  wr_data;

    logic               wr_en1, start1, busy1, done1;
    logic [3:0]         rd_addr1;
    logic signed [15:0] rd_data1;

    logic               wr_en2, start2, busy2, done2;
    logic [2:0]         rd_addr2;
    logic signed [17:0] rd_data2;

    int n_chk = 0;
    int n_err = 0;
    int a1 [9], b1 [9], exp1 [9];
    int a2 [8], b2 [12], exp2 [6];
    int first_k, nd, val;

    systolic_matmul #(.M(3), .KD(3), .N(3), .DATA_WIDTH(8), .ACC_WIDTH(16)) u_dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en1), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start1), .busy(busy1), .done(done1),
        .rd_addr(rd_addr1), .rd_data(rd_data1)
    );

    systolic_matmul #(.M(2), .KD(4), .N(3)) u_dut2 (
        .clk(clk), .reset(reset), .wr_en(wr_en2), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start2), .busy(busy2), .done(done2),
        .rd_addr(rd_addr2), .rd_data(rd_data2)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr(input bit dut, input bit sel, input int addr, input int data);
        @(negedge clk);
        wr_en1 = !dut; wr_en2 = dut; wr_sel = sel;
        wr_addr = 4'(addr); wr_data = 8'(data);
        @(negedge clk);
        wr_en1 = 1'b0; wr_en2 = 1'b0;
    endtask

    task automatic load1();
        for (int i = 0; i < 9; i++) wr(1'b0, 1'b0, i, a1[i]);
        for (int i = 0; i < 9; i++) wr(1'b0, 1'b1, i, b1[i]);
    endtask

    task automatic check_c1(input string tag);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); rd_addr1 = 4'(i);
            @(negedge clk); check($sformatf("%s[%0d]", tag, i), int'(rd_data1), exp1[i]);
        end
    endtask

    // Pulse start, watch a fixed window and report first done cycle and done count.
    task automatic run(input bit dut, input bit disturb, output int fk, output int n);
        @(negedge clk);
        if (dut) start2 = 1'b1; else start1 = 1'b1;
        fk = -1; n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start1 = 1'b0; start2 = 1'b0;
                check("busy_after_start", int'(dut ? busy2 : busy1), 1);
            end
            if (disturb && k == 4) begin
                start1 = 1'b1; wr_en1 = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'sd7;
            end
            if (disturb && k == 5) begin
                start1 = 1'b0; wr_en1 = 1'b0;
            end
            if ((dut ? done2 : done1) === 1'b1) begin
                n++;
                if (fk < 0) fk = k;
            end
        end
    endtask

    initial begin
        reset = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        wr_en1 = 1'b0; start1 = 1'b0; rd_addr1 = '0;
        wr_en2 = 1'b0; start2 = 1'b0; rd_addr2 = '0;

        @(negedge clk);
        check("rst_busy", int'(busy1), 0);
        check("rst_done", int'(done1), 0);
        check("rst_rd", int'(rd_data1), 0);
        @(negedge clk);
        reset = 1'b1;

        // Identity A, B = 1..9
        for (int i = 0; i < 9; i++) begin
            a1[i] = (i % 4 == 0) ? 1 : 0; b1[i] = i + 1; exp1[i] = i + 1;
        end
        load1();
        run(1'b0, 1'b0, first_k, nd);
        check("ident_done_cycle", first_k, 8);
        check("ident_done_count", nd, 1);
        check_c1("ident_c");

        // Back-to-back: start held through DONE into first IDLE, with A[0][0]=5
        rd_addr1 = 4'd4;
        @(negedge clk); start1 = 1'b1; first_k = -1;
        for (int k = 1; k <= 20 && first_k < 0; k++) begin
            @(negedge clk);
            if (k == 1) start1 = 1'b0;
            if (done1 === 1'b1) first_k = k;
        end
        check("b2b_done1", first_k, 8);
        start1 = 1'b1; wr_en1 = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'sd5;
        @(negedge clk);
        check("b2b_hold_a", int'(rd_data1), 5);
        @(negedge clk);
        start1 = 1'b0; wr_en1 = 1'b0;
        check("b2b_hold_b", int'(rd_data1), 5);
        first_k = -1; nd = 0;
        for (int k = 11; k <= 30; k++) begin
            @(negedge clk);
            if (done1 === 1'b1) begin
                nd++;
                if (first_k < 0) first_k = k;
            end
        end
        check("b2b_done2", first_k, 17);
        check("b2b_done2_count", nd, 1);
        exp1 = '{5, 10, 15, 4, 5, 6, 7, 8, 9};
        check_c1("b2b_c");

        // Start and write during COMPUTE are ignored
        wr(1'b0, 1'b0, 0, 1);
        for (int i = 0; i < 9; i++) exp1[i] = i + 1;
        run(1'b0, 1'b1, first_k, nd);
        check("dist_done_cycle", first_k, 8);
        check("dist_done_count", nd, 1);
        check_c1("dist_c");

        // Wraparound: all -128, 3 * 16384 = 49152 wraps to -16384 in 16 bits
        for (int i = 0; i < 9; i++) begin
            a1[i] = -128; b1[i] = -128; exp1[i] = -16384;
        end
        load1();
        run(1'b0, 1'b0, first_k, nd);
        check("wrap_done_cycle", first_k, 8);
        check_c1("wrap_c");

        // Rectangular 2x4 * 4x3
        a2 = '{1, 2, 3, 4, -1, 0, 1, 2};
        for (int i = 0; i < 12; i++) b2[i] = 1;
        exp2 = '{10, 10, 10, 2, 2, 2};
        for (int i = 0; i < 8; i++)  wr(1'b1, 1'b0, i, a2[i]);
        for (int i = 0; i < 12; i++) wr(1'b1, 1'b1, i, b2[i]);
        run(1'b1, 1'b0, first_k, nd);
        check("rect_done_cycle", first_k, 8);
        check("rect_done_count", nd, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); rd_addr2 = 3'(i);
            @(negedge clk); check($sformatf("rect_c[%0d]", i), int'(rd_data2), exp2[i]);
        end

        // Reset during COMPUTE cycle 4 aborts
        rd_addr1 = 4'd8;
        @(negedge clk); start1 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) start1 = 1'b0;
        end
        reset = 1'b0;
        #1;
        check("abort_busy", int'(busy1), 0);
        check("abort_done", int'(done1), 0);
        check("abort_rd", int'(rd_data1), 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done1 === 1'b1) nd++;
        end
        check("abort_no_done", nd, 0);
        check("abort_idle", int'(busy1), 0);
        @(negedge clk);
        check("abort_acc_zero", int'(rd_data1), 0);
        for (int i = 0; i < 9; i++) begin
            a1[i] = (i % 4 == 0) ? 1 : 0; b1[i] = i + 1; exp1[i] = i + 1;
        end
        load1();
        run(1'b0, 1'b0, first_k, nd);
        check("rerun_done_cycle", first_k, 8);
        check_c1("rerun_c");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/systolic_matmul.md
SYSTOLIC_MATMUL -- requirements
Module: systolic_matmul

Interface
REQ-001 SHALL have parameter M, default 3: rows of A and C; number of PE rows.
REQ-002 SHALL have parameter KD, default 3: columns of A and rows of B (inner dimension).
REQ-003 SHALL have parameter N, default 3: columns of B and C; number of PE columns.
REQ-004 SHALL have parameter DATA_WIDTH, default 8: signed A/B element width.
REQ-005 SHALL have parameter ACC_WIDTH, default 2*DATA_WIDTH+$clog2(KD): signed accumulator and C element width.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 wr_en  input  1  write one A or B element this cycle.
REQ-009 wr_sel  input  1  0 = A buffer, 1 = B buffer.
REQ-010 wr_addr  input  $clog2(max(M*KD, KD*N))  row-major element address.
REQ-011 wr_data  input  DATA_WIDTH  signed element.
REQ-012 start  input  1  begin multiplication, sampled in IDLE only.
REQ-013 busy  output  1  high in COMPUTE and DONE.
REQ-014 done  output  1  one-cycle pulse, results valid.
REQ-015 rd_addr  input  $clog2(M*N)  C address, i*N+j.
REQ-016 rd_data  output  ACC_WIDTH  C[rd_addr], registered, 1-cycle latency.

Function
REQ-017 Addressing SHALL be A[i][k] at i*KD+k and B[k][j] at k*N+j; out-of-range writes SHALL be dropped.
REQ-018 Writes SHALL be accepted only in IDLE; writes while busy SHALL be ignored.
REQ-019 FSM SHALL have states IDLE, COMPUTE, DONE: IDLE->COMPUTE on start; COMPUTE->DONE after T = KD+M+N-2 cycles; DONE->IDLE after one cycle.
REQ-020 On the start edge, all M*N accumulators SHALL clear and the cycle counter SHALL load 0.
REQ-021 In COMPUTE cycle t (0..T-1), PE(i,j) SHALL add A[i][k]*B[k][j] with k = t-i-j when 0<=k<KD, else add nothing.
REQ-022 Operands SHALL be fed skewed: row i of A enters the left edge delayed i cycles; column j of B enters the top edge delayed j cycles; each PE forwards a rightward and b downward with one-cycle register delay.
REQ-023 Products SHALL be full 2*DATA_WIDTH signed, sign-extended to ACC_WIDTH; accumulation SHALL wrap modulo 2^ACC_WIDTH without saturation or flag.
REQ-024 done SHALL be high exactly in the DONE cycle, T+1 cycles after the start edge.
REQ-025 start while busy SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-026 C SHALL hold the last results until the next accepted start; rd_data SHALL reflect reads issued in any state.
REQ-027 Degenerate M=N=KD=1 SHALL give T=1.

Reset
REQ-028 On reset low: state IDLE, counter 0, busy 0, done 0, rd_data 0, all accumulators and pipeline registers 0, immediately and asynchronously.
REQ-029 A/B buffer contents SHALL be zeroed on reset.
REQ-030 Reset asserted mid-COMPUTE SHALL abort; after release the block SHALL be in IDLE with no done pulse.

Structure
REQ-031 Shared package systolic_pkg SHALL hold the FSM state typedef and a clog2/max width helper; M, KD, N, DATA_WIDTH, ACC_WIDTH remain module parameters.
REQ-032 One sub-module systolic_pe SHALL implement the PE (a/b forwarding registers, valid bit, MAC accumulator, clear input), instantiated M*N times in a generate grid.

Verification
REQ-033 3x3 A = identity, B = 1..9 row-major, start -> done at cycle 8 after start, C = 1..9.
REQ-034 M=2, KD=4, N=3, A=[[1,2,3,4],[-1,0,1,2]], B all 1 -> done at cycle 8, C row0 = 10,10,10, row1 = 2,2,2.
REQ-035 DATA_WIDTH=8, ACC_WIDTH=16, KD=3, all A=B=-128 -> each C = 49152 mod 2^16 = -16384 (0xC000).
REQ-036 start pulsed again at cycle 3 of COMPUTE, plus wr_en during COMPUTE -> ignored; single done; results unchanged from REQ-033 stimulus.
REQ-037 Reset asserted at COMPUTE cycle 4 -> busy/done 0 immediately; no done; rerun after reload yields correct C.
REQ-038 Back-to-back: start on the first IDLE cycle after done with new A -> second done T+1 cycles later; C between runs holds first results.
